// File: rtl/ring_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ring_seq_ctrl
//  Description : Run/stop sequencer, programmable ring strobe, one-hot ring
//                register and round-robin load arbiter for the counter datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_seq_ctrl #(
  parameter int CNT_W  = 4,
  parameter int RING_W = 6,
  parameter int DIV_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              req_a,
  input  logic [CNT_W-1:0]  data_a,
  input  logic              req_b,
  input  logic [CNT_W-1:0]  data_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              cnt_ld,
  output logic [CNT_W-1:0]  cnt_din,
  output logic              cnt_en,
  output logic              ring_stb,
  output logic [RING_W-1:0] ring,
  output logic              wrap,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [RING_W-1:0] c_ring_one = RING_W'(1);

  state_t             r_state,      w_state_nxt;
  state_t             r_resume,     w_resume_nxt;
  logic [DIV_W-1:0]   r_pre,        w_pre_nxt;
  logic [DIV_W-1:0]   r_div_q,      w_div_q_nxt;
  logic [RING_W-1:0]  r_ring,       w_ring_nxt;
  logic               r_last_b,     w_last_b_nxt;
  logic               r_gnt_b,      w_gnt_b_nxt;
  logic               r_stop_seen,  w_stop_seen_nxt;
  logic               r_start_seen, w_start_seen_nxt;

  logic               w_run;
  logic               w_load;
  logic               w_stb;

  assign w_run  = (r_state == ST_RUN);
  assign w_load = (r_state == ST_LOAD);
  assign w_stb  = w_run && (r_pre == r_div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_resume     <= ST_IDLE;
      r_pre        <= '0;
      r_div_q      <= '0;
      r_ring       <= c_ring_one;
      r_last_b     <= 1'b1;
      r_gnt_b      <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_start_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_resume     <= w_resume_nxt;
      r_pre        <= w_pre_nxt;
      r_div_q      <= w_div_q_nxt;
      r_ring       <= w_ring_nxt;
      r_last_b     <= w_last_b_nxt;
      r_gnt_b      <= w_gnt_b_nxt;
      r_stop_seen  <= w_stop_seen_nxt;
      r_start_seen <= w_start_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_resume_nxt     = r_resume;
    w_pre_nxt        = r_pre;
    w_div_q_nxt      = r_div_q;
    w_ring_nxt       = r_ring;
    w_last_b_nxt     = r_last_b;
    w_gnt_b_nxt      = r_gnt_b;
    w_stop_seen_nxt  = r_stop_seen;
    w_start_seen_nxt = r_start_seen;

    if (w_stb) begin
      w_ring_nxt = r_ring[RING_W-1] ? c_ring_one : (r_ring << 1);
    end

    unique case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_run) begin
          w_pre_nxt = w_stb ? '0 : r_pre + DIV_W'(1);
        end
        if (req_a || req_b) begin
          // Contention goes to the side not served last; a lone request wins outright.
          w_gnt_b_nxt      = (req_a && req_b) ? ~r_last_b : req_b;
          w_last_b_nxt     = w_gnt_b_nxt;
          w_resume_nxt     = r_state;
          w_stop_seen_nxt  = stop;
          w_start_seen_nxt = start;
          w_state_nxt      = ST_LOAD;
        end else if (stop && w_run) begin
          w_state_nxt = ST_IDLE;
          w_pre_nxt   = '0;
        end else if (start && !w_run) begin
          w_state_nxt = ST_RUN;
          w_div_q_nxt = div_val;
          w_pre_nxt   = '0;
        end
      end
      ST_LOAD: begin
        // Stop seen in the entry or load cycle beats any start.
        if (r_stop_seen || stop) begin
          w_state_nxt = ST_IDLE;
          w_pre_nxt   = '0;
        end else if (r_start_seen || start) begin
          w_state_nxt = ST_RUN;
          if (r_resume == ST_IDLE) begin
            w_div_q_nxt = div_val;
            w_pre_nxt   = '0;
          end
        end else begin
          w_state_nxt = r_resume;
        end
        w_stop_seen_nxt  = 1'b0;
        w_start_seen_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack_a    = w_load && !r_gnt_b;
  assign ack_b    = w_load &&  r_gnt_b;
  assign cnt_ld   = w_load;
  assign cnt_din  = w_load ? (r_gnt_b ? data_b : data_a) : '0;
  assign cnt_en   = w_run;
  assign ring_stb = w_stb;
  assign ring     = r_ring;
  assign wrap     = w_stb && r_ring[RING_W-1];
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ring_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_seq_ctrl
//  Description : Vector table, directed corner sequences and randomized run
//                against a behavioural model of ring_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_seq_ctrl;
  localparam int CNT_W  = 4;
  localparam int RING_W = 6;
  localparam int DIV_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0;
  logic [DIV_W-1:0]  div_val = '0;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic [CNT_W-1:0]  data_a = '0, data_b = '0;
  logic              ack_a, ack_b, cnt_ld, cnt_en, ring_stb, wrap, busy;
  logic [CNT_W-1:0]  cnt_din;
  logic [RING_W-1:0] ring;

  int total = 0;
  int bad   = 0;

  ring_seq_ctrl #(.CNT_W(CNT_W), .RING_W(RING_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div_val(div_val),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .cnt_ld(cnt_ld), .cnt_din(cnt_din),
    .cnt_en(cnt_en), .ring_stb(ring_stb), .ring(ring), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, p;
    logic [DIV_W-1:0] dv;
    logic ra;
    logic [CNT_W-1:0] da;
    logic rb;
    logic [CNT_W-1:0] db;
    logic e_acka, e_ackb, e_ld;
    logic [CNT_W-1:0] e_din;
    logic e_en, e_stb;
    logic [RING_W-1:0] e_ring;
    logic e_wrap, e_busy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ea, input logic eb, input logic eld,
                         input logic [CNT_W-1:0] edin, input logic een, input logic estb,
                         input logic [RING_W-1:0] ering, input logic ewrap, input logic ebusy);
    chk({tag, ".ack_a"},    32'(ack_a),    32'(ea));
    chk({tag, ".ack_b"},    32'(ack_b),    32'(eb));
    chk({tag, ".cnt_ld"},   32'(cnt_ld),   32'(eld));
    chk({tag, ".cnt_din"},  32'(cnt_din),  32'(edin));
    chk({tag, ".cnt_en"},   32'(cnt_en),   32'(een));
    chk({tag, ".ring_stb"}, 32'(ring_stb), 32'(estb));
    chk({tag, ".ring"},     32'(ring),     32'(ering));
    chk({tag, ".wrap"},     32'(wrap),     32'(ewrap));
    chk({tag, ".busy"},     32'(busy),     32'(ebusy));
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are settled 1 time unit later.
  task automatic drive(input logic r, input logic s, input logic p, input logic [DIV_W-1:0] dv,
                       input logic ra, input logic [CNT_W-1:0] da,
                       input logic rb, input logic [CNT_W-1:0] db);
    @(negedge clk);
    rst = r; start = s; stop = p; div_val = dv;
    req_a = ra; data_a = da; req_b = rb; data_b = db;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic [DIV_W-1:0] dv,
                              input logic ra, input logic [CNT_W-1:0] da,
                              input logic rb, input logic [CNT_W-1:0] db,
                              input logic ea, input logic eb, input logic eld,
                              input logic [CNT_W-1:0] edin, input logic een, input logic estb,
                              input logic [RING_W-1:0] ering, input logic ewrap, input logic ebusy);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.dv = dv; v.ra = ra; v.da = da; v.rb = rb; v.db = db;
    v.e_acka = ea; v.e_ackb = eb; v.e_ld = eld; v.e_din = edin; v.e_en = een;
    v.e_stb = estb; v.e_ring = ering; v.e_wrap = ewrap; v.e_busy = ebusy;
    return v;
  endfunction

  // Behavioural model: modes 0=idle 1=run 2=load; ring kept as a position index.
  int m_mode, m_pre, m_per, m_idx, m_last, m_gnt, m_entry;
  bit m_sstop, m_sstart;

  function automatic void m_reset();
    m_mode = 0; m_pre = 0; m_per = 0; m_idx = 0; m_last = 1; m_gnt = 0;
    m_entry = 0; m_sstop = 0; m_sstart = 0;
  endfunction

  function automatic void m_step(input bit r, input bit s, input bit p, input int dv,
                                 input bit ra, input bit rb);
    bit run, stb;
    int nxt;
    run = (m_mode == 1);
    stb = run && (m_pre == m_per);
    if (r) begin
      m_reset();
      return;
    end
    if (stb) m_idx = (m_idx + 1) % RING_W;
    if (m_mode != 2) begin
      if (run) m_pre = stb ? 0 : m_pre + 1;
      if (ra || rb) begin
        m_gnt   = (ra && rb) ? 1 - m_last : (rb ? 1 : 0);
        m_last  = m_gnt;
        m_entry = m_mode;
        m_sstop = p; m_sstart = s;
        m_mode  = 2;
      end else if (p && run) begin
        m_mode = 0; m_pre = 0;
      end else if (s && !run) begin
        m_mode = 1; m_per = dv; m_pre = 0;
      end
    end else begin
      nxt = (m_sstop || p) ? 0 : ((m_sstart || s) ? 1 : m_entry);
      if (nxt == 0) m_pre = 0;
      else if (m_entry == 0) begin
        m_per = dv; m_pre = 0;
      end
      m_mode = nxt; m_sstop = 0; m_sstart = 0;
    end
  endfunction

  bit r_r, r_s, r_p, r_ra, r_rb;
  bit pend_a, pend_b, cool_a, cool_b;
  logic [CNT_W-1:0] dat_a, dat_b, r_da, r_db;
  logic [DIV_W-1:0] r_dv;
  bit e_run, e_ld, e_stb, e_acka, e_ackb;
  logic [CNT_W-1:0] e_din;

  initial begin
    tbl[0]  = mk('0,'0,'0,2'd0, '0,4'd0,'0,4'd0,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[1]  = mk('0,'0,'0,2'd0, '1,4'd5,'1,4'd9,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[2]  = mk('0,'0,'0,2'd0, '1,4'd5,'1,4'd9,  '1,'0,'1,4'd5,'0,'0,6'd1,'0,'1);
    tbl[3]  = mk('0,'0,'0,2'd0, '0,4'd0,'1,4'd9,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[4]  = mk('0,'0,'0,2'd0, '0,4'd0,'1,4'd9,  '0,'1,'1,4'd9,'0,'0,6'd1,'0,'1);
    tbl[5]  = mk('0,'0,'0,2'd0, '0,4'd0,'0,4'd0,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[6]  = mk('0,'0,'0,2'd0, '1,4'd5,'1,4'd9,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[7]  = mk('0,'0,'0,2'd0, '1,4'd5,'1,4'd9,  '1,'0,'1,4'd5,'0,'0,6'd1,'0,'1);
    tbl[8]  = mk('0,'0,'0,2'd0, '0,4'd0,'1,4'd9,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);
    tbl[9]  = mk('1,'0,'0,2'd0, '0,4'd0,'1,4'd9,  '0,'1,'1,4'd9,'0,'0,6'd1,'0,'1);
    tbl[10] = mk('0,'0,'0,2'd0, '0,4'd0,'0,4'd0,  '0,'0,'0,4'd0,'0,'0,6'd1,'0,'0);

    repeat (2) @(posedge clk);

    // Reset state, arbitration ordering and reset during a load cycle
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].dv, tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_acka, tbl[i].e_ackb, tbl[i].e_ld, tbl[i].e_din,
              tbl[i].e_en, tbl[i].e_stb, tbl[i].e_ring, tbl[i].e_wrap, tbl[i].e_busy);
    end

    // Period-4 strobe, full ring lap with wrap, then simultaneous stop+start
    drive('0, '1, '0, 2'd3, '0, 4'd0, '0, 4'd0);
    chk_all("start", '0, '0, '0, 4'd0, '0, '0, 6'd1, '0, '0);
    for (int k = 1; k <= 30; k++) begin
      int idx;
      idx = ((k - 1) / 4) % RING_W;
      drive('0, (k == 30), (k == 30), 2'd0, '0, 4'd0, '0, 4'd0);
      chk_all($sformatf("run%0d", k), '0, '0, '0, 4'd0, '1, (k % 4 == 0),
              RING_W'(1 << idx), ((k % 4 == 0) && idx == RING_W - 1), '1);
    end
    drive('0, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    chk_all("stopped", '0, '0, '0, 4'd0, '0, '0, 6'd2, '0, '0);

    // Load from B mid-period slips the strobe by one cycle
    drive('0, '1, '0, 2'd3, '0, 4'd0, '0, 4'd0);
    chk_all("start2", '0, '0, '0, 4'd0, '0, '0, 6'd2, '0, '0);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    chk_all("slip_p0", '0, '0, '0, 4'd0, '1, '0, 6'd2, '0, '1);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '1, 4'd7);
    chk_all("slip_req", '0, '0, '0, 4'd0, '1, '0, 6'd2, '0, '1);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '1, 4'd7);
    chk_all("slip_load", '0, '1, '1, 4'd7, '0, '0, 6'd2, '0, '1);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    chk_all("slip_p2", '0, '0, '0, 4'd0, '1, '0, 6'd2, '0, '1);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    chk_all("slip_stb", '0, '0, '0, 4'd0, '1, '1, 6'd2, '0, '1);

    // Request together with stop: load first, then idle
    drive('0, '0, '1, 2'd0, '1, 4'd3, '0, 4'd0);
    chk_all("rs_req", '0, '0, '0, 4'd0, '1, '0, 6'd4, '0, '1);
    drive('0, '0, '0, 2'd0, '1, 4'd3, '0, 4'd0);
    chk_all("rs_load", '1, '0, '1, 4'd3, '0, '0, 6'd4, '0, '1);
    drive('0, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    chk_all("rs_idle", '0, '0, '0, 4'd0, '0, '0, 6'd4, '0, '0);

    // Randomized traffic against the model
    drive('1, '0, '0, 2'd0, '0, 4'd0, '0, 4'd0);
    m_reset();
    pend_a = 0; pend_b = 0; cool_a = 0; cool_b = 0; dat_a = '0; dat_b = '0;
    for (int c = 0; c < 3000; c++) begin
      r_r  = ($urandom_range(63) == 0);
      r_s  = ($urandom_range(7) == 0);
      r_p  = ($urandom_range(11) == 0);
      r_dv = DIV_W'($urandom);
      if (cool_a) begin
        r_ra = 0; cool_a = 0;
      end else begin
        if (!pend_a && $urandom_range(4) == 0) begin
          pend_a = 1; dat_a = CNT_W'($urandom);
        end
        r_ra = pend_a;
      end
      if (cool_b) begin
        r_rb = 0; cool_b = 0;
      end else begin
        if (!pend_b && $urandom_range(4) == 0) begin
          pend_b = 1; dat_b = CNT_W'($urandom);
        end
        r_rb = pend_b;
      end
      r_da = pend_a ? dat_a : CNT_W'($urandom);
      r_db = pend_b ? dat_b : CNT_W'($urandom);
      drive(r_r, r_s, r_p, r_dv, r_ra, r_da, r_rb, r_db);

      e_run  = (m_mode == 1);
      e_ld   = (m_mode == 2);
      e_stb  = e_run && (m_pre == m_per);
      e_acka = e_ld && (m_gnt == 0);
      e_ackb = e_ld && (m_gnt == 1);
      e_din  = e_ld ? ((m_gnt == 1) ? r_db : r_da) : '0;
      chk_all("rnd", e_acka, e_ackb, e_ld, e_din, e_run, e_stb, RING_W'(1 << m_idx),
              e_stb && (m_idx == RING_W - 1), m_mode != 0);

      if (e_acka) begin
        pend_a = 0; cool_a = 1;
      end
      if (e_ackb) begin
        pend_b = 0; cool_b = 1;
      end
      m_step(r_r, r_s, r_p, int'(r_dv), r_ra, r_rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
